// File: rtl/hpdcache_mem_req_rr_credit_arbiter.sv
// Round-robin arbiter that shares one memory read-request channel among N
// requesters. Each requester holds a credit counter of in-flight
// transactions and is skipped while that counter sits at MAX_OUTSTANDING.
// Once a grant is presented and stalled, it is locked until its handshake.
//
// Optional build macro HPDCACHE_ARB_PERF_EN: when it is defined,
// perf_blocked_o counts the cycles in which a valid requester was
// credit-blocked. When it is not defined, perf_blocked_o is tied to zero.
module hpdcache_mem_req_rr_credit_arbiter #(
    parameter int unsigned N               = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter type         hpdcache_mem_req_t = logic,
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N-1:0]                 req_valid_i,
    output logic [N-1:0]                 req_ready_o,
    input  hpdcache_mem_req_t [N-1:0]    req_i,
    input  logic                         mem_req_ready_i,
    output logic                         mem_req_valid_o,
    output hpdcache_mem_req_t            mem_req_o,
    output logic [IW-1:0]                gnt_index_o,
    input  logic                         rsp_done_i,
    input  logic [IW-1:0]                rsp_done_idx_i,
    output logic [N-1:0][CW-1:0]         outstanding_o,
    output logic                         idle_o,
    output logic [31:0]                  perf_blocked_o
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [IW-1:0]         ptr_q, ptr_d;
    logic                  lock_q, lock_d;
    logic [IW-1:0]         lock_idx_q, lock_idx_d;
    logic [IW-1:0]         gnt_q, gnt_d;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]          full;
    logic [N-1:0]          eligible;
    logic                  hi_found, lo_found, scan_found;
    logic [IW-1:0]         hi_idx, lo_idx, scan_idx;
    logic                  lock_elig;
    logic [IW-1:0]         gnt_sel;
    logic                  hs;
    logic [N-1:0]          inc_vec, dec_vec;
    logic                  rsp_idx_ok;
    logic                  rsp_cnt_nz;

    // Credit state: a requester is eligible only while it has credit left
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            full[i] = (cnt_q[i] == MAX_CNT);
        end
        eligible = req_valid_i & ~full;
    end

    // Rotating priority scan: first look at indices at or above ptr, then wrap to the bottom
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hi_found && eligible[i] && (IW'(i) >= ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!lo_found && eligible[i]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
            end
        end
        scan_found = hi_found | lo_found;
        scan_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Grant selection; a stalled grant stays locked on its index
    always_comb begin
        lock_elig = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IW'(i) == lock_idx_q) begin
                lock_elig = eligible[i];
            end
        end
        gnt_sel         = lock_q ? lock_idx_q : scan_idx;
        mem_req_valid_o = lock_q ? lock_elig : scan_found;
        hs              = mem_req_valid_o & mem_req_ready_i;
    end

    // Payload mux, per-requester ready, and the visible grant index
    always_comb begin
        mem_req_o   = req_i[0];
        req_ready_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IW'(i) == gnt_sel) begin
                mem_req_o      = req_i[i];
                req_ready_o[i] = hs;
            end
        end
        gnt_index_o = mem_req_valid_o ? gnt_sel : gnt_q;
    end

    // Pointer, lock, and last-grant next state
    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        gnt_d      = gnt_q;
        if (mem_req_valid_o) begin
            gnt_d = gnt_sel;
        end
        if (hs) begin
            lock_d = 1'b0;
            ptr_d  = (gnt_sel == IW'(N - 1)) ? '0 : gnt_sel + IW'(1);
        end else if (mem_req_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_sel;
        end
    end

    // Credit counters: +1 on handshake, -1 on completion, and both together cancel
    always_comb begin
        inc_vec    = '0;
        dec_vec    = '0;
        rsp_idx_ok = 1'b0;
        rsp_cnt_nz = 1'b0;
        cnt_d      = cnt_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (rsp_done_idx_i == IW'(i)) begin
                rsp_idx_ok = 1'b1;
                rsp_cnt_nz = (cnt_q[i] != '0);
            end
            inc_vec[i] = hs && (gnt_sel == IW'(i));
            dec_vec[i] = rsp_done_i && (rsp_done_idx_i == IW'(i)) && (cnt_q[i] != '0);
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign idle_o        = (cnt_q == '0) && (req_valid_i == '0);

`ifdef HPDCACHE_ARB_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of cycles with at least one credit-blocked valid requester
    always_comb begin
        perf_d = perf_q;
        if (((req_valid_i & full) != '0) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_blocked_o = perf_q;
`else
    assign perf_blocked_o = 32'd0;
`endif

`ifndef SYNTHESIS
    // Completions must name an existing requester that has a transaction in flight
    always_ff @(posedge clk_i) begin
        if (!rst_i && rsp_done_i) begin
            assert (rsp_idx_ok)
                else $error("rsp_done_idx_i out of range");
            assert (!rsp_idx_ok || rsp_cnt_nz)
                else $error("rsp_done_i on requester with no outstanding transaction");
        end
    end
`endif

endmodule

// File: tb/tb_hpdcache_mem_req_rr_credit_arbiter.sv
// Randomized bench for the round-robin credit arbiter, checked against a
// transaction-level model of grants, locks and credit counts.
module tb_hpdcache_mem_req_rr_credit_arbiter;

    localparam int NREQ = 4;
    localparam int MAXO = 3;
    localparam int CW   = 2;
    localparam int IW   = 2;

    typedef logic [15:0] pay_t;

    logic                     clk;
    logic                     rst;
    logic [NREQ-1:0]          vld;
    logic [NREQ-1:0]          rdy_o;
    pay_t [NREQ-1:0]          pay;
    logic                     mem_rdy;
    logic                     mem_vld;
    pay_t                     mem_pay;
    logic [IW-1:0]            gnt_idx;
    logic                     done;
    logic [IW-1:0]            done_idx;
    logic [NREQ-1:0][CW-1:0]  outst;
    logic                     idle;
    logic [31:0]              perf;

    hpdcache_mem_req_rr_credit_arbiter #(
        .N                  (NREQ),
        .MAX_OUTSTANDING    (MAXO),
        .hpdcache_mem_req_t (pay_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (vld),
        .req_ready_o     (rdy_o),
        .req_i           (pay),
        .mem_req_ready_i (mem_rdy),
        .mem_req_valid_o (mem_vld),
        .mem_req_o       (mem_pay),
        .gnt_index_o     (gnt_idx),
        .rsp_done_i      (done),
        .rsp_done_idx_i  (done_idx),
        .outstanding_o   (outst),
        .idle_o          (idle),
        .perf_blocked_o  (perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_cnt [NREQ];
    int m_ptr;
    bit m_lock;
    int m_lock_idx;
    int m_last;
    int m_perf;
    int hs_prev;
    int exp_g;
    int blocked;
    int nz [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr      = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        m_last     = 0;
        m_perf     = 0;
        hs_prev    = -1;
    endtask

    task automatic check_reset_state();
        chk("rst_valid", 32'(mem_vld), 32'd0);
        chk("rst_ready", 32'(rdy_o), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_gnt", 32'(gnt_idx), 32'd0);
        chk("rst_perf", perf, 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rst_cnt%0d", i), 32'(outst[i]), 32'd0);
        end
    endtask

    // Compare all DUT outputs against the model for the inputs currently driven
    task automatic check_cycle();
        int  exp_perf;
        bit  exp_idle;
        exp_g = -1;
        if (m_lock) begin
            if (vld[m_lock_idx] && m_cnt[m_lock_idx] < MAXO) exp_g = m_lock_idx;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (exp_g < 0 && vld[j] && m_cnt[j] < MAXO) exp_g = j;
            end
        end
        exp_idle = (vld == '0);
        for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) exp_idle = 1'b0;
`ifdef HPDCACHE_ARB_PERF_EN
        exp_perf = m_perf;
`else
        exp_perf = 0;
`endif
        chk("valid", 32'(mem_vld), (exp_g >= 0) ? 32'd1 : 32'd0);
        chk("gnt_index", 32'(gnt_idx), (exp_g >= 0) ? 32'(exp_g) : 32'(m_last));
        chk("req_ready", 32'(rdy_o), (exp_g >= 0 && mem_rdy) ? (32'd1 << exp_g) : 32'd0);
        if (exp_g >= 0) chk("payload", 32'(mem_pay), 32'(pay[exp_g]));
        chk("idle", 32'(idle), 32'(exp_idle));
        chk("perf", perf, 32'(exp_perf));
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("cnt%0d", i), 32'(outst[i]), 32'(m_cnt[i]));
        end
    endtask

    // Random inputs that respect the hold-until-ready protocol
    task automatic drive_cycle();
        if (hs_prev >= 0) vld[hs_prev] = 1'b0;
        hs_prev = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld[i] && $urandom_range(0, 1) == 1) begin
                vld[i] = 1'b1;
                pay[i] = 16'($urandom);
            end
        end
        mem_rdy  = ($urandom_range(0, 3) != 0);
        done     = 1'b0;
        done_idx = 2'($urandom_range(0, NREQ - 1));
        if ($urandom_range(0, 1) == 1) begin
            nz.delete();
            for (int i = 0; i < NREQ; i++) if (m_cnt[i] > 0) nz.push_back(i);
            if (nz.size() > 0) begin
                done     = 1'b1;
                done_idx = 2'(nz[$urandom_range(0, nz.size() - 1)]);
            end
        end
    endtask

    // Advance the model by one clock using the rules of the arbiter
    task automatic model_step();
        blocked = 0;
        for (int i = 0; i < NREQ; i++) if (vld[i] && m_cnt[i] == MAXO) blocked = 1;
        if (exp_g >= 0) begin
            m_last = exp_g;
            if (mem_rdy) begin
                m_cnt[exp_g]++;
                m_ptr   = (exp_g + 1) % NREQ;
                m_lock  = 1'b0;
                hs_prev = exp_g;
            end else begin
                m_lock     = 1'b1;
                m_lock_idx = exp_g;
            end
        end
        if (done && m_cnt[done_idx] > 0) m_cnt[done_idx]--;
        if (blocked != 0) m_perf++;
    endtask

    initial begin
        rst      = 1'b1;
        vld      = '0;
        pay      = '0;
        mem_rdy  = 1'b0;
        done     = 1'b0;
        done_idx = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1000 || cyc == 2000) begin
                // Reset in the middle of traffic, usually with counters and a lock live
                drive_cycle();
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst      = 1'b0;
                vld      = '0;
                mem_rdy  = 1'b0;
                done     = 1'b0;
                model_reset();
                #1;
                check_reset_state();
            end else begin
                drive_cycle();
                #1;
                check_cycle();
                @(posedge clk);
                model_step();
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hpdcache_mem_req_rr_credit_arbiter.md
Name: hpdcache_mem_req_rr_credit_arbiter

Overview:
- Round-robin arbiter that shares one memory read request channel between N requesters, e.g. the miss handler, prefetcher and uncached unit.
- Tracks outstanding transactions per requester and caps each at MAX_OUTSTANDING, so one source cannot starve the response buffers.
- Sits between the requesters' request queues and the memory interface request port.
- Forwards the grant index so the caller can tag the request.

Parameters:
- N, 4, number of requesters; must be at least 1.
- MAX_OUTSTANDING, 8, maximum in-flight requests per requester; must be at least 1.
- hpdcache_mem_req_t, logic, request payload type.
- Derived: CW = $clog2(MAX_OUTSTANDING+1), the credit counter width.
- Derived: IW = (N>1 ? $clog2(N) : 1), the index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  N  per-requester request valid.
- req_ready_o  out  N  per-requester ready; at most one bit high.
- req_i  in  N x $bits(hpdcache_mem_req_t)  per-requester payload.
- mem_req_ready_i  in  1  downstream ready.
- mem_req_valid_o  out  1  downstream valid.
- mem_req_o  out  $bits(hpdcache_mem_req_t)  muxed payload.
- gnt_index_o  out  IW  binary index of the current grant.
- rsp_done_i  in  1  pulse: one transaction of a requester has completed.
- rsp_done_idx_i  in  IW  requester index for rsp_done_i.
- outstanding_o  out  N x CW  per-requester in-flight count.
- idle_o  out  1  high when all counters are 0 and no request is pending.
- perf_blocked_o  out  32  credit-blocked cycle counter (see Optional Feature).

Behaviour:
- One clock only. Everything is synchronous to clk_i and cleared by rst_i at the rising edge.
- Reset values:
  - round-robin pointer = 0
  - all counters = 0
  - lock = 0
  - perf_blocked_o = 0
  - idle_o = 1
  - mem_req_valid_o = 0 and req_ready_o = 0, provided inputs are deasserted
- eligible[i] = req_valid_i[i] && (outstanding[i] < MAX_OUTSTANDING).
- Grant selection, when unlocked: the first eligible index scanning ptr, ptr+1, ..., wrapping modulo N. This is combinational, with zero-cycle latency from valid to mem_req_valid_o.
- Grant hold:
  - If mem_req_valid_o=1 and mem_req_ready_i=0, set the lock and latch the granted index.
  - While locked, the grant does not change even if another requester becomes eligible.
  - Requesters must hold valid and payload stable until ready.
  - Lock clears on handshake.
- Outputs:
  - mem_req_valid_o = granted requester's valid and eligibility (from the locked index when locked).
  - mem_req_o = payload of the granted requester.
  - gnt_index_o = granted index; it holds its last value when nothing is granted.
- req_ready_o[g] = mem_req_ready_i && mem_req_valid_o, only for g equal to the grant. The ready path is combinational from mem_req_ready_i.
- Handshake on requester g:
  - ptr <= (g+1) mod N.
  - outstanding[g] increments.
  - The pointer does not move when there is no handshake.
- rsp_done_i=1 decrements outstanding[rsp_done_idx_i].
  - If the same cycle also has a handshake on the same index, the counter is unchanged.
  - Different indices update independently.
- Decrement at 0 is ignored (counter stays 0); the simulation assertion fires.
- Handshake with counter at MAX_OUTSTANDING is impossible by construction.
- Credit full:
  - A requester at MAX_OUTSTANDING is skipped, and the next eligible requester is granted the same cycle.
  - A locked grant cannot become credit-blocked, because the counter only grows on its own handshake.
- rsp_done_idx_i >= N is ignored, with an assertion.
- Reset mid-transfer drops the lock and counters. Upstream must also reset, since in-flight responses are forgotten.
- N=1: the pointer is constant 0; the behaviour is otherwise identical.

Optional Feature:
- Macro: HPDCACHE_ARB_PERF_EN.
- Defined: perf_blocked_o counts cycles where some req_valid_i[i]=1 with outstanding[i]=MAX_OUTSTANDING.
  - Increments by 1 per such cycle, regardless of how many requesters are blocked.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- Not defined: perf_blocked_o is tied to 32'd0 and no counter flops are inferred. The port list is identical in both builds.

Test Plan:
- Round robin, N=4, MAX=8, all requesters always valid, mem_req_ready_i=1, rsp_done_i pulsed each cycle for the previous grant -> gnt_index_o sequence 0,1,2,3,0,... with one handshake per cycle and no counter above 1.
- Grant hold: only requester 2 valid, mem_req_ready_i=0 for 5 cycles, requester 0 raises valid at cycle 2 -> gnt_index_o stays 2 and mem_req_o stays stable for all 5 cycles; ready at cycle 6 gives req_ready_o=4'b0100, then requester 0 wins.
- Credit cap, MAX=2: requester 1 sends 2 requests with no responses -> outstanding_o[1]=2 and requester 1 is skipped while requester 3 is granted. One rsp_done_i with idx=1 -> counter 1, requester 1 becomes eligible again.
- Simultaneous events: handshake on requester 0 and rsp_done_i idx=0 in the same cycle with counter 3 -> counter stays 3. Handshake idx=0 with done idx=1 (1 -> 0) -> counters 4 and 0.
- Reset: assert rst_i with a locked grant and counters {2,1,0,3} -> next cycle shows counters 0, ptr 0, idle_o=1, and with HPDCACHE_ARB_PERF_EN perf_blocked_o=0.
- Perf counter: with HPDCACHE_ARB_PERF_EN, MAX=1, requester 0 valid and blocked for 10 cycles -> perf_blocked_o=10. Without the macro -> perf_blocked_o=0.
